multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 49 ++++
 rtl/alu_decoder.sv | 23 ++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit: states, opcodes,
// funct codes and the datapath select/ULA encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ULAControl decode; funct_ok drops for unsupported functs.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ula_ctrl,
  output logic       funct_ok
);

  always_comb begin
    ula_ctrl = ULA_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  ula_ctrl = ULA_ADD;
      FN_SUB:  ula_ctrl = ULA_SUB;
      FN_AND:  ula_ctrl = ULA_AND;
      FN_OR:   ula_ctrl = ULA_OR;
      FN_SLT:  ula_ctrl = ULA_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: Moore mux selects, write strobes gated by the en step
// pulse so each write happens exactly once per state.
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ULAControl,
  output logic       IRWrite,
  output logic       PCEn,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam state_t FAULT_NEXT = ILLEGAL_HALT ? S_HALT : S_FETCH;

  state_t     state_q, state_d;
  logic [2:0] fn_ula;
  logic       fn_ok;
  logic       ir_write_s, pc_write_s, reg_write_s, mem_write_s, branch_s, bad_s;
  logic       gate;

  alu_decoder u_alu_decoder (
    .funct    (funct),
    .ula_ctrl (fn_ula),
    .funct_ok (fn_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    IorD        = 1'b0;
    ALUSrcA     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSrc       = PCSRC_ULA;
    ULAControl  = ULA_AND;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    branch_s    = 1'b0;
    bad_s       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = SRCB_ONE;
        ULAControl = ULA_ADD;
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        if (en) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM;
        ULAControl = ULA_ADD;
        case (op)
          OP_LW, OP_SW:   if (en) state_d = S_MEMADR;
          OP_RTYPE:       if (en) state_d = S_EXEC;
          OP_BEQ, OP_BNE: if (en) state_d = S_BRANCH;
          OP_ADDI:        if (en) state_d = S_ADDIEX;
          OP_J:           if (en) state_d = S_JUMP;
          default: begin
            bad_s = 1'b1;
            if (en) state_d = FAULT_NEXT;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ULAControl = ULA_ADD;
        if (en) begin
          if (state_q == S_ADDIEX) state_d = S_ADDIWB;
          else                     state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (en) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_s = 1'b1;
        if (en) state_d = S_FETCH;
      end
      S_MEMWR: begin
        IorD        = 1'b1;
        mem_write_s = 1'b1;
        if (en) state_d = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ULAControl = fn_ula;
        bad_s      = ~fn_ok;
        if (en) state_d = fn_ok ? S_ALUWB : FAULT_NEXT;
      end
      S_ALUWB, S_ADDIWB: begin
        RegDst      = (state_q == S_ALUWB);
        reg_write_s = 1'b1;
        if (en) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ULAControl = ULA_SUB;
        PCSrc      = PCSRC_ALUOUT;
        branch_s   = 1'b1;
        if (en) state_d = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pc_write_s = 1'b1;
        if (en) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are combinational so zero is seen in the same cycle as the write.
  assign gate     = en & ~rst;
  assign IRWrite  = gate & ir_write_s;
  assign RegWrite = gate & reg_write_s;
  assign MemWrite = gate & mem_write_s;
  assign illegal  = gate & bad_s;
  assign PCEn     = gate & (pc_write_s |
                            (branch_s & (op == OP_BEQ) & zero) |
                            (branch_s & (op == OP_BNE) & ~zero));
  assign state_o  = state_q;

endmodule
